csr_trap_ctrl: RTL and testbench

- Drives the internal-write side of the CSR file: per-CSR InternalWriteEn/InternalWriteData that the top level merges into csr_control.
- Sequences machine-mode trap entry (mepc, mcause, mtval, mstatus updates) and mret return.
- Hands the redirect PC to fetch over a valid/ready handshake.
- Keeps the mcycle/minstret counters advancing; it reads the current CSR values back through csr_values.

---
 rtl/csr_trap_ctrl_pkg.sv | 49 ++++
 rtl/csr_trap_ctrl_counter_inc.sv | 36 +++
 rtl/csr_trap_ctrl.sv | 172 +++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared CSR-file constants, trap FSM state type and mstatus update helpers
// used by the trap controller and its counter incrementers.
package ZICSRType;

    localparam int XLEN      = 32;
    localparam int CSR_COUNT = 9;

    localparam int CSR_MSTATUS   = 0;
    localparam int CSR_MTVEC     = 1;
    localparam int CSR_MEPC      = 2;
    localparam int CSR_MCAUSE    = 3;
    localparam int CSR_MTVAL     = 4;
    localparam int CSR_MCYCLE    = 5;
    localparam int CSR_MCYCLEH   = 6;
    localparam int CSR_MINSTRET  = 7;
    localparam int CSR_MINSTRETH = 8;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        TRAP_COMMIT,
        MRET_COMMIT,
        REDIRECT
    } trapState;

    function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] v;
        v                       = s;
        v[MSTATUS_MPIE]         = s[MSTATUS_MIE];
        v[MSTATUS_MIE]          = 1'b0;
        v[MSTATUS_MPP_LO +: 2]  = 2'b11;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] v;
        v                       = s;
        v[MSTATUS_MIE]          = s[MSTATUS_MPIE];
        v[MSTATUS_MPIE]         = 1'b1;
        v[MSTATUS_MPP_LO +: 2]  = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/csr_trap_ctrl_counter_inc.sv
// One performance counter's increment: low half always, high half on low-half
// wrap (32-bit only); a software write to any counter suppresses the update.
module csr_counter_inc
    import ZICSRType::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic            i_inc,
    input  logic            i_sw_write,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_hi,
    output logic            o_lo_we,
    output logic            o_hi_we,
    output logic [XLEN-1:0] o_lo_data,
    output logic [XLEN-1:0] o_hi_data
);

    logic w_go;
    logic w_lo_wrap;

    assign w_go      = ENABLE && i_inc && !i_sw_write;
    assign w_lo_wrap = (i_lo == '1);
    assign o_lo_we   = w_go;
    assign o_lo_data = i_lo + XLEN'(1);

    generate
        if (XLEN == 32) begin : g_split
            assign o_hi_we   = w_go && w_lo_wrap;
            assign o_hi_data = i_hi + XLEN'(1);
        end else begin : g_flat
            assign o_hi_we   = 1'b0;
            assign o_hi_data = '0;
        end
    endgenerate

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer and counter driver for the CSR file's
// internal write port. Write enables/data are combinational; all else registered.
module csr_trap_ctrl
    import ZICSRType::*;
#(
    parameter bit VECTORED_EN = 1'b1,
    parameter bit COUNTERS_EN = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           TrapReq,
    input  logic                           TrapIsInt,
    input  logic [XLEN-2:0]                TrapCause,
    input  logic [XLEN-1:0]                TrapPC,
    input  logic [XLEN-1:0]                TrapVal,
    input  logic                           MretReq,
    input  logic                           InstrRetired,
    input  logic                           CounterSwWrite,
    input  logic [CSR_COUNT-1:0][XLEN-1:0] csr_values,
    output logic [CSR_COUNT-1:0]           InternalWriteEn,
    output logic [CSR_COUNT-1:0][XLEN-1:0] InternalWriteData,
    output logic                           RedirectValid,
    output logic [XLEN-1:0]                RedirectPC,
    input  logic                           RedirectReady,
    output logic                           Busy
);

    trapState        r_state;
    trapState        w_state_next;
    logic            r_is_int;
    logic [XLEN-2:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_val;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_redirect_valid;
    logic            r_busy;

    logic [XLEN-1:0] w_mtvec;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_off;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_target;

    logic            w_cyc_lo_we;
    logic            w_cyc_hi_we;
    logic [XLEN-1:0] w_cyc_lo_data;
    logic [XLEN-1:0] w_cyc_hi_data;
    logic            w_ret_lo_we;
    logic            w_ret_hi_we;
    logic [XLEN-1:0] w_ret_lo_data;
    logic [XLEN-1:0] w_ret_hi_data;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (TrapReq) begin
                    w_state_next = TRAP_COMMIT;
                end else if (MretReq) begin
                    w_state_next = MRET_COMMIT;
                end
            end
            TRAP_COMMIT: w_state_next = REDIRECT;
            MRET_COMMIT: w_state_next = REDIRECT;
            REDIRECT: begin
                if (RedirectReady) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Vector offset is cause<<2 kept to XLEN bits, so the cause MSBs fall off.
    assign w_mtvec       = csr_values[CSR_MTVEC];
    assign w_base        = {w_mtvec[XLEN-1:2], 2'b00};
    assign w_vec_off     = {r_cause[XLEN-3:0], 2'b00};
    assign w_vectored    = VECTORED_EN && (w_mtvec[1:0] == MTVEC_MODE_VECTORED) && r_is_int;
    assign w_trap_target = w_vectored ? (w_base + w_vec_off) : w_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= IDLE;
            r_is_int         <= 1'b0;
            r_cause          <= '0;
            r_pc             <= '0;
            r_val            <= '0;
            r_redirect_pc    <= '0;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_busy           <= (w_state_next != IDLE);
            r_redirect_valid <= (w_state_next == REDIRECT);
            if (r_state == IDLE && TrapReq) begin
                r_is_int <= TrapIsInt;
                r_cause  <= TrapCause;
                r_pc     <= TrapPC;
                r_val    <= TrapVal;
            end
            if (r_state == TRAP_COMMIT) begin
                r_redirect_pc <= w_trap_target;
            end else if (r_state == MRET_COMMIT) begin
                r_redirect_pc <= csr_values[CSR_MEPC];
            end
        end
    end

    csr_counter_inc #(
        .ENABLE (COUNTERS_EN)
    ) u_mcycle (
        .i_inc      (1'b1),
        .i_sw_write (CounterSwWrite),
        .i_lo       (csr_values[CSR_MCYCLE]),
        .i_hi       (csr_values[CSR_MCYCLEH]),
        .o_lo_we    (w_cyc_lo_we),
        .o_hi_we    (w_cyc_hi_we),
        .o_lo_data  (w_cyc_lo_data),
        .o_hi_data  (w_cyc_hi_data)
    );

    csr_counter_inc #(
        .ENABLE (COUNTERS_EN)
    ) u_minstret (
        .i_inc      (InstrRetired),
        .i_sw_write (CounterSwWrite),
        .i_lo       (csr_values[CSR_MINSTRET]),
        .i_hi       (csr_values[CSR_MINSTRETH]),
        .o_lo_we    (w_ret_lo_we),
        .o_hi_we    (w_ret_hi_we),
        .o_lo_data  (w_ret_lo_data),
        .o_hi_data  (w_ret_hi_data)
    );

    // Reset gates the write port so no CSR is touched while the sequence is abandoned.
    always_comb begin
        InternalWriteEn   = '0;
        InternalWriteData = '0;
        if (!reset) begin
            case (r_state)
                TRAP_COMMIT: begin
                    InternalWriteEn[CSR_MEPC]      = 1'b1;
                    InternalWriteEn[CSR_MCAUSE]    = 1'b1;
                    InternalWriteEn[CSR_MTVAL]     = 1'b1;
                    InternalWriteEn[CSR_MSTATUS]   = 1'b1;
                    InternalWriteData[CSR_MEPC]    = {r_pc[XLEN-1:2], 2'b00};
                    InternalWriteData[CSR_MCAUSE]  = {r_is_int, r_cause};
                    InternalWriteData[CSR_MTVAL]   = r_val;
                    InternalWriteData[CSR_MSTATUS] = mstatus_on_trap(csr_values[CSR_MSTATUS]);
                end
                MRET_COMMIT: begin
                    InternalWriteEn[CSR_MSTATUS]   = 1'b1;
                    InternalWriteData[CSR_MSTATUS] = mstatus_on_mret(csr_values[CSR_MSTATUS]);
                end
                default: ;
            endcase
            InternalWriteEn[CSR_MCYCLE]      = w_cyc_lo_we;
            InternalWriteEn[CSR_MCYCLEH]     = w_cyc_hi_we;
            InternalWriteEn[CSR_MINSTRET]    = w_ret_lo_we;
            InternalWriteEn[CSR_MINSTRETH]   = w_ret_hi_we;
            InternalWriteData[CSR_MCYCLE]    = w_cyc_lo_data;
            InternalWriteData[CSR_MCYCLEH]   = w_cyc_hi_data;
            InternalWriteData[CSR_MINSTRET]  = w_ret_lo_data;
            InternalWriteData[CSR_MINSTRETH] = w_ret_hi_data;
        end
    end

    assign RedirectValid = r_redirect_valid;
    assign RedirectPC    = r_redirect_pc;
    assign Busy          = r_busy;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a small CSR file plant merges the internal writes,
// and an arithmetic reference model predicts CSR contents and redirect targets.
module tb_csr_trap_ctrl;
    import ZICSRType::*;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           TrapReq;
    logic                           TrapIsInt;
    logic [XLEN-2:0]                TrapCause;
    logic [XLEN-1:0]                TrapPC;
    logic [XLEN-1:0]                TrapVal;
    logic                           MretReq;
    logic                           InstrRetired;
    logic                           CounterSwWrite;
    logic [CSR_COUNT-1:0][XLEN-1:0] csr_values;
    logic [CSR_COUNT-1:0]           InternalWriteEn;
    logic [CSR_COUNT-1:0][XLEN-1:0] InternalWriteData;
    logic                           RedirectValid;
    logic [XLEN-1:0]                RedirectPC;
    logic                           RedirectReady;
    logic                           Busy;

    logic [CSR_COUNT-1:0]           v0_we;
    logic [CSR_COUNT-1:0][XLEN-1:0] v0_wd;
    logic                           v0_valid;
    logic [XLEN-1:0]                v0_pc;
    logic                           v0_busy;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.VECTORED_EN(1'b1), .COUNTERS_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .TrapReq(TrapReq), .TrapIsInt(TrapIsInt),
        .TrapCause(TrapCause), .TrapPC(TrapPC), .TrapVal(TrapVal), .MretReq(MretReq),
        .InstrRetired(InstrRetired), .CounterSwWrite(CounterSwWrite), .csr_values(csr_values),
        .InternalWriteEn(InternalWriteEn), .InternalWriteData(InternalWriteData),
        .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
        .RedirectReady(RedirectReady), .Busy(Busy)
    );

    csr_trap_ctrl #(.VECTORED_EN(1'b0), .COUNTERS_EN(1'b1)) dut_direct (
        .clk(clk), .reset(reset), .TrapReq(TrapReq), .TrapIsInt(TrapIsInt),
        .TrapCause(TrapCause), .TrapPC(TrapPC), .TrapVal(TrapVal), .MretReq(MretReq),
        .InstrRetired(InstrRetired), .CounterSwWrite(CounterSwWrite), .csr_values(csr_values),
        .InternalWriteEn(v0_we), .InternalWriteData(v0_wd),
        .RedirectValid(v0_valid), .RedirectPC(v0_pc),
        .RedirectReady(RedirectReady), .Busy(v0_busy)
    );

    // CSR file plant: internal writes merged, bench (software) write has priority.
    logic [CSR_COUNT-1:0][XLEN-1:0] csr;
    logic                           tb_clr;
    logic                           tb_wr_en;
    int                             tb_wr_idx;
    logic [XLEN-1:0]                tb_wr_data;

    always_ff @(posedge clk) begin
        if (tb_clr) begin
            csr <= '0;
        end else begin
            for (int i = 0; i < CSR_COUNT; i++) begin
                if (InternalWriteEn[i]) csr[i] <= InternalWriteData[i];
            end
            if (tb_wr_en) csr[tb_wr_idx] <= tb_wr_data;
        end
    end
    assign csr_values = csr;

    // Reference model of the CSR contents.
    logic [63:0] m_cycle, m_instret;
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        ir_force;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        InstrRetired = ir_force ? 1'b1 : 1'($urandom_range(0, 1));
        if (!reset && !tb_clr) begin
            if (CounterSwWrite) begin
                if (tb_wr_en) begin
                    case (tb_wr_idx)
                        CSR_MCYCLE:    m_cycle[31:0]    = tb_wr_data;
                        CSR_MCYCLEH:   m_cycle[63:32]   = tb_wr_data;
                        CSR_MINSTRET:  m_instret[31:0]  = tb_wr_data;
                        CSR_MINSTRETH: m_instret[63:32] = tb_wr_data;
                        default: ;
                    endcase
                end
            end else begin
                m_cycle = m_cycle + 64'd1;
                if (InstrRetired) m_instret = m_instret + 64'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sw_write(input int idx, input logic [31:0] d);
        tb_wr_en       = 1'b1;
        tb_wr_idx      = idx;
        tb_wr_data     = d;
        CounterSwWrite = (idx == CSR_MCYCLE || idx == CSR_MCYCLEH ||
                          idx == CSR_MINSTRET || idx == CSR_MINSTRETH);
        case (idx)
            CSR_MSTATUS: m_mstatus = d;
            CSR_MTVEC:   m_mtvec   = d;
            CSR_MEPC:    m_mepc    = d;
            CSR_MCAUSE:  m_mcause  = d;
            CSR_MTVAL:   m_mtval   = d;
            default: ;
        endcase
        step();
        tb_wr_en       = 1'b0;
        CounterSwWrite = 1'b0;
    endtask

    task automatic check_counters();
        chk("mcycle",    csr[CSR_MCYCLE],    m_cycle[31:0]);
        chk("mcycleh",   csr[CSR_MCYCLEH],   m_cycle[63:32]);
        chk("minstret",  csr[CSR_MINSTRET],  m_instret[31:0]);
        chk("minstreth", csr[CSR_MINSTRETH], m_instret[63:32]);
    endtask

    // Redirect wait phase shared by trap and mret; optional TrapReq poke while busy.
    task automatic redirect_phase(input logic [31:0] exp_pc, input logic [31:0] exp_pc_direct,
                                  input int wait_n, input logic poke);
        for (int n = 0; n <= wait_n; n++) begin
            RedirectReady = (n == wait_n);
            TrapReq       = poke && (n == 0);
            step();
            TrapReq       = 1'b0;
            if (n < wait_n) begin
                chk("wait_valid", 32'(RedirectValid), 32'd1);
                chk("wait_pc", RedirectPC, exp_pc);
                chk("wait_busy", 32'(Busy), 32'd1);
            end
        end
        RedirectReady = 1'b0;
        chk("done_valid", 32'(RedirectValid), 32'd0);
        chk("done_busy", 32'(Busy), 32'd0);
        chk("done_direct_valid", 32'(v0_valid), 32'd0);
        chk("done_mepc", csr[CSR_MEPC], m_mepc);
        chk("done_mcause", csr[CSR_MCAUSE], m_mcause);
        chk("done_mstatus", csr[CSR_MSTATUS], m_mstatus);
        check_counters();
    endtask

    task automatic do_trap(input logic isint, input logic [30:0] cause, input logic [31:0] pc,
                           input logic [31:0] val, input int wait_n, input logic with_mret,
                           input logic poke);
        logic [31:0] base, exp_pc, exp_st;
        base   = m_mtvec & 32'hFFFF_FFFC;
        exp_pc = (m_mtvec[1:0] == 2'b01 && isint) ?
                 32'(longint'(base) + longint'(cause) * 4) : base;
        exp_st = (m_mstatus & ~32'h0000_1888) | (m_mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
        TrapReq = 1'b1; TrapIsInt = isint; TrapCause = cause; TrapPC = pc; TrapVal = val;
        MretReq = with_mret;
        step();
        TrapReq   = 1'b0; MretReq = 1'b0;
        TrapIsInt = 1'($urandom_range(0, 1));
        TrapCause = 31'($urandom); TrapPC = $urandom; TrapVal = $urandom;
        chk("commit_busy", 32'(Busy), 32'd1);
        chk("commit_valid", 32'(RedirectValid), 32'd0);
        step();
        m_mepc = pc & 32'hFFFF_FFFC; m_mcause = {isint, cause}; m_mtval = val; m_mstatus = exp_st;
        chk("trap_mepc", csr[CSR_MEPC], m_mepc);
        chk("trap_mcause", csr[CSR_MCAUSE], m_mcause);
        chk("trap_mtval", csr[CSR_MTVAL], m_mtval);
        chk("trap_mstatus", csr[CSR_MSTATUS], m_mstatus);
        chk("trap_valid", 32'(RedirectValid), 32'd1);
        chk("trap_pc", RedirectPC, exp_pc);
        chk("trap_pc_direct", v0_pc, base);
        redirect_phase(exp_pc, base, wait_n, poke);
    endtask

    task automatic do_mret(input int wait_n, input logic poke);
        logic [31:0] exp_st, exp_pc;
        exp_pc = m_mepc;
        exp_st = (m_mstatus & ~32'h0000_1888) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
        MretReq = 1'b1;
        step();
        MretReq = 1'b0;
        chk("mret_commit_busy", 32'(Busy), 32'd1);
        step();
        m_mstatus = exp_st;
        chk("mret_mstatus", csr[CSR_MSTATUS], m_mstatus);
        chk("mret_valid", 32'(RedirectValid), 32'd1);
        chk("mret_pc", RedirectPC, exp_pc);
        chk("mret_pc_direct", v0_pc, exp_pc);
        redirect_phase(exp_pc, exp_pc, wait_n, poke);
    endtask

    initial begin
        reset = 1'b1; TrapReq = 1'b0; TrapIsInt = 1'b0; TrapCause = '0; TrapPC = '0;
        TrapVal = '0; MretReq = 1'b0; InstrRetired = 1'b0; CounterSwWrite = 1'b0;
        RedirectReady = 1'b0; tb_clr = 1'b1; tb_wr_en = 1'b0; tb_wr_idx = 0;
        tb_wr_data = '0; ir_force = 1'b0;
        m_cycle = '0; m_instret = '0; m_mstatus = '0; m_mtvec = '0; m_mepc = '0;
        m_mcause = '0; m_mtval = '0;

        step();
        tb_clr = 1'b0;
        step();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(RedirectValid), 32'd0);
        chk("rst_pc", RedirectPC, 32'd0);
        chk("rst_we", 32'(InternalWriteEn), 32'd0);
        chk("rst_wdata", 32'(|InternalWriteData), 32'd0);
        chk("rst_direct_we", 32'(v0_we), 32'd0);
        chk("rst_direct_wdata", 32'(|v0_wd), 32'd0);
        check_counters();
        reset = 1'b0;
        step();
        check_counters();

        // Direct trap entry.
        sw_write(CSR_MTVEC, 32'h8000_0100);
        sw_write(CSR_MSTATUS, 32'h0000_0008);
        do_trap(1'b0, 31'd2, 32'h1004, 32'hDEAD, 0, 1'b0, 1'b0);
        chk("tp1_mepc", csr[CSR_MEPC], 32'h1004);
        chk("tp1_mstatus", csr[CSR_MSTATUS], 32'h0000_1880);

        // Vectored interrupt.
        sw_write(CSR_MTVEC, 32'h8000_0101);
        do_trap(1'b1, 31'd7, 32'h3002, 32'h0, 1, 1'b0, 1'b0);
        chk("vec_mcause", csr[CSR_MCAUSE], 32'h8000_0007);

        // mret with a stalled fetch, plus a TrapReq pulse while busy.
        sw_write(CSR_MEPC, 32'h2000);
        sw_write(CSR_MSTATUS, 32'h0000_0080);
        do_mret(3, 1'b1);
        chk("mret_mie", 32'(csr[CSR_MSTATUS][3]), 32'd1);

        // Simultaneous trap and mret: trap wins, mret dropped.
        do_trap(1'b0, 31'd11, 32'h4444, 32'h55, 2, 1'b1, 1'b1);
        step();
        step();
        chk("drop_valid", 32'(RedirectValid), 32'd0);
        chk("drop_busy", 32'(Busy), 32'd0);

        // 32-bit counter carry and software-write suppression.
        sw_write(CSR_MCYCLEH, 32'd5);
        sw_write(CSR_MCYCLE, 32'hFFFF_FFFF);
        chk("cyc_pre", csr[CSR_MCYCLE], 32'hFFFF_FFFF);
        step();
        chk("cyc_wrap_lo", csr[CSR_MCYCLE], 32'd0);
        chk("cyc_wrap_hi", csr[CSR_MCYCLEH], 32'd6);
        sw_write(CSR_MCYCLE, 32'h10);
        chk("cyc_sw", csr[CSR_MCYCLE], 32'h10);
        step();
        chk("cyc_sw_next", csr[CSR_MCYCLE], 32'h11);
        sw_write(CSR_MINSTRETH, 32'd9);
        sw_write(CSR_MINSTRET, 32'hFFFF_FFFF);
        ir_force = 1'b1;
        step();
        ir_force = 1'b0;
        chk("ret_wrap_lo", csr[CSR_MINSTRET], 32'd0);
        chk("ret_wrap_hi", csr[CSR_MINSTRETH], 32'd10);
        check_counters();

        // Reset while in TRAP_COMMIT abandons the sequence.
        TrapReq = 1'b1; TrapIsInt = 1'b1; TrapCause = 31'd3; TrapPC = 32'h9990; TrapVal = 32'h77;
        step();
        TrapReq = 1'b0;
        reset = 1'b1;
        #1;
        chk("rmid_we", 32'(InternalWriteEn), 32'd0);
        step();
        step();
        chk("rmid_mepc", csr[CSR_MEPC], m_mepc);
        chk("rmid_mcause", csr[CSR_MCAUSE], m_mcause);
        chk("rmid_valid", 32'(RedirectValid), 32'd0);
        chk("rmid_busy", 32'(Busy), 32'd0);
        chk("rmid_pc", RedirectPC, 32'd0);
        check_counters();
        reset = 1'b0;
        step();
        do_trap(1'b1, 31'd3, 32'h9990, 32'h77, 0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                0, 1: sw_write(CSR_MTVEC, {$urandom_range(0, 32'hFFFF_FFFF)} & 32'hFFFF_FFFD);
                2:    sw_write(CSR_MSTATUS, $urandom);
                3, 4, 5, 6:
                    do_trap(1'($urandom_range(0, 1)), 31'($urandom), $urandom, $urandom,
                            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                7, 8: do_mret(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                default: begin
                    step();
                    check_counters();
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
